regbank_access_ctrl: RTL and testbench
======================================

Name: regbank_access_ctrl

Overview:
- Arbiter and sequencer in front of the 8x8-bit register bank of the Nano MIPS core.
- Shares the bank's single operation slot between three requesters: writeback (write), operand fetch (dual read) and a debug dump sequencer that streams out all 8 registers.
- The bank does either a write or a dual read per clock edge, never both, so this block picks one operation per cycle.
- Drives bank_wrEn/addresses/write data; passes returned read data to the owner of the previous read slot.

Parameters:
- WR_STREAK_MAX, 4: consecutive write grants allowed while rd_req is pending before one read is forced through (range 1..15).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- wb_req  in  1  writeback request
- wb_addr  in  3  write register index
- wb_data  in  8  write data
- wb_ack  out  1  combinational; write performed at this edge
- rd_req  in  1  operand read request
- rd_addr1  in  3  first read index
- rd_addr2  in  3  second read index
- rd_ack  out  1  combinational; read issued at this edge
- rd_valid  out  1  data valid, cycle after rd_ack
- rd_data1  out  8  first operand
- rd_data2  out  8  second operand
- dump_start  in  1  pulse; start full-bank dump
- dump_busy  out  1  dump in progress
- dump_valid  out  1  dump pair valid
- dump_idx  out  3  even index of current pair (0,2,4,6)
- dump_data_lo  out  8  register dump_idx
- dump_data_hi  out  8  register dump_idx+1
- dump_done  out  1  one-cycle pulse with last pair
- bank_wrEn  out  1  to bank write enable
- bank_addR1  out  3  to bank read address 1
- bank_addR2  out  3  to bank read address 2
- bank_addWr  out  3  to bank write address
- bank_dadoWr  out  8  to bank write data
- bank_dadoR1  in  8  from bank read port 1
- bank_dadoR2  in  8  from bank read port 2

Behaviour:
- Reset (rst=0 at edge):
  - state=IDLE, pair counter=0, streak=0, rd_valid=0, dump_valid=0, dump_done=0, dump_busy=0.
  - While rst=0, all acks=0 and bank_wrEn=0, so no bank write races the bank's own clear.
  - Reset mid-dump aborts the dump with no dump_done.
- Arbitration, decided combinationally each cycle:
  - If wb_req=1 and not (rd_req=1 and streak==WR_STREAK_MAX): write. wb_ack=1, bank_wrEn=1, bank_addWr/bank_dadoWr=wb_addr/wb_data.
  - Else if rd_req=1: read. rd_ack=1, bank_wrEn=0, bank_addR1/2=rd_addr1/2.
  - Else if state=DUMP: dump read. bank_addR1=2*pair, bank_addR2=2*pair+1.
  - Else: idle read. bank_wrEn=0, addresses 0; the result is discarded.
- Streak counter:
  - Increments on a write grant while rd_req=1.
  - Clears on a read grant or when rd_req=0.
  - Saturates at WR_STREAK_MAX.
- Read latency is 1 cycle:
  - rd_valid=1 exactly in the cycle after rd_ack, with rd_data1/2 = bank_dadoR1/2 passthrough.
  - dump_valid follows the same rule for dump slots.
  - Both valids are registered ownership flags and are never 1 together.
- Write-to-read ordering: a write granted at edge N is visible to a read issued at edge N+1 or later. No bypass.
- FSM states:
  - IDLE: dump_start=1 -> DUMP, pair=0, dump_busy=1.
  - DUMP: each dump slot won increments pair. The slot for pair 3 moves to FLUSH.
  - FLUSH: dump_valid=1 for pair 3, dump_done=1, dump_busy=0 next cycle -> IDLE.
- dump_start while dump_busy=1 is ignored.
- Dump has lowest priority and may stall indefinitely under continuous rd_req/wb_req; pair does not advance while stalled.
- dump_idx is registered with the slot and equals 2*pair of the issued slot.

Test Plan:
- Reset then wb_req writes r3=0x5A at edge N; rd_req r3,r0 at N+1 -> rd_ack=1 at N+1, rd_valid=1 at N+2 with rd_data1=0x5A, rd_data2=0x00.
- wb_req and rd_req both asserted in one cycle -> wb_ack=1, rd_ack=0; read granted the next cycle after wb_req drops.
- Continuous wb_req plus rd_req, WR_STREAK_MAX=4 -> write acks for 4 cycles, read ack on the 5th cycle, then the pattern repeats; rd_valid follows each read ack by one cycle.
- Load r0..r7 = 0x10..0x17, pulse dump_start with no other traffic -> 4 dump_valid cycles, pairs (0,0x10,0x11), (2,0x12,0x13), (4,0x14,0x15), (6,0x16,0x17), dump_done on the last; second dump_start during dump ignored.
- Dump interleaved with rd_req on alternate cycles -> dump advances only on free cycles, all 4 pairs correct, rd_valid and dump_valid never both 1.
- rst=0 asserted during dump pair 2 while wb_req=1 -> bank_wrEn=0 and all acks=0 during reset, no dump_done; after reset dump_busy=0 and reads return 0x00.

Source files
------------

// File: rtl/regbank_access_ctrl.sv
// Single-slot arbiter for the 8x8 register bank: writeback, operand read and debug dump share one op per edge.
// Acks are combinational; read/dump data return one cycle after their slot.
module regbank_access_ctrl #(
  parameter int unsigned WR_STREAK_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wb_req,
  input  logic [2:0] wb_addr,
  input  logic [7:0] wb_data,
  output logic       wb_ack,
  input  logic       rd_req,
  input  logic [2:0] rd_addr1,
  input  logic [2:0] rd_addr2,
  output logic       rd_ack,
  output logic       rd_valid,
  output logic [7:0] rd_data1,
  output logic [7:0] rd_data2,
  input  logic       dump_start,
  output logic       dump_busy,
  output logic       dump_valid,
  output logic [2:0] dump_idx,
  output logic [7:0] dump_data_lo,
  output logic [7:0] dump_data_hi,
  output logic       dump_done,
  output logic       bank_wrEn,
  output logic [2:0] bank_addR1,
  output logic [2:0] bank_addR2,
  output logic [2:0] bank_addWr,
  output logic [7:0] bank_dadoWr,
  input  logic [7:0] bank_dadoR1,
  input  logic [7:0] bank_dadoR2
);

  localparam logic [3:0] STREAK_MAX = 4'(WR_STREAK_MAX);

  typedef enum logic [1:0] {IDLE, DUMP, FLUSH} state_t;

  state_t     state_q;
  logic [1:0] pair_q;
  logic [3:0] streak_q;
  logic       rd_valid_q;
  logic       dump_valid_q;
  logic       dump_done_q;
  logic       dump_busy_q;
  logic [2:0] dump_idx_q;

  logic wr_grant;
  logic rd_grant;
  logic dump_slot;

  // All grants are held off while rst is low so nothing races the bank's own clear.
  always_comb begin
    wr_grant   = 1'b0;
    rd_grant   = 1'b0;
    dump_slot  = 1'b0;
    bank_addR1 = 3'd0;
    bank_addR2 = 3'd0;
    if (rst) begin
      wr_grant  = wb_req && !(rd_req && (streak_q == STREAK_MAX));
      rd_grant  = rd_req && !wr_grant;
      dump_slot = (state_q == DUMP) && !wr_grant && !rd_grant;
    end
    if (rd_grant) begin
      bank_addR1 = rd_addr1;
      bank_addR2 = rd_addr2;
    end else if (dump_slot) begin
      bank_addR1 = {pair_q, 1'b0};
      bank_addR2 = {pair_q, 1'b1};
    end
  end

  assign wb_ack      = wr_grant;
  assign rd_ack      = rd_grant;
  assign bank_wrEn   = wr_grant;
  assign bank_addWr  = wb_addr;
  assign bank_dadoWr = wb_data;

  assign rd_valid     = rd_valid_q;
  assign rd_data1     = bank_dadoR1;
  assign rd_data2     = bank_dadoR2;
  assign dump_valid   = dump_valid_q;
  assign dump_idx     = dump_idx_q;
  assign dump_data_lo = bank_dadoR1;
  assign dump_data_hi = bank_dadoR2;
  assign dump_done    = dump_done_q;
  assign dump_busy    = dump_busy_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      pair_q       <= 2'd0;
      streak_q     <= 4'd0;
      rd_valid_q   <= 1'b0;
      dump_valid_q <= 1'b0;
      dump_done_q  <= 1'b0;
      dump_busy_q  <= 1'b0;
      dump_idx_q   <= 3'd0;
    end else begin
      rd_valid_q   <= rd_grant;
      dump_valid_q <= dump_slot;
      dump_done_q  <= 1'b0;
      if (dump_slot) dump_idx_q <= {pair_q, 1'b0};

      // Streak only counts writes that actually made a pending read wait.
      if (!rd_req || rd_grant)
        streak_q <= 4'd0;
      else if (wr_grant && (streak_q != STREAK_MAX))
        streak_q <= streak_q + 4'd1;

      case (state_q)
        IDLE: begin
          if (dump_start) begin
            state_q     <= DUMP;
            pair_q      <= 2'd0;
            dump_busy_q <= 1'b1;
          end
        end
        DUMP: begin
          if (dump_slot) begin
            pair_q <= pair_q + 2'd1;
            if (pair_q == 2'd3) begin
              state_q     <= FLUSH;
              dump_done_q <= 1'b1;
            end
          end
        end
        FLUSH: begin
          state_q     <= IDLE;
          dump_busy_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regbank_access_ctrl.sv
// Bench for regbank_access_ctrl with a behavioural 8x8 bank (registered reads, sync clear on rst low).
module tb_regbank_access_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wb_req = 1'b0;
  logic [2:0] wb_addr = '0;
  logic [7:0] wb_data = '0;
  logic       wb_ack;
  logic       rd_req = 1'b0;
  logic [2:0] rd_addr1 = '0;
  logic [2:0] rd_addr2 = '0;
  logic       rd_ack, rd_valid;
  logic [7:0] rd_data1, rd_data2;
  logic       dump_start = 1'b0;
  logic       dump_busy, dump_valid, dump_done;
  logic [2:0] dump_idx;
  logic [7:0] dump_data_lo, dump_data_hi;
  logic       bank_wrEn;
  logic [2:0] bank_addR1, bank_addR2, bank_addWr;
  logic [7:0] bank_dadoWr;
  logic [7:0] bank_dadoR1, bank_dadoR2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regbank_access_ctrl #(.WR_STREAK_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ack(wb_ack),
    .rd_req(rd_req), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_ack(rd_ack),
    .rd_valid(rd_valid), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
    .dump_idx(dump_idx), .dump_data_lo(dump_data_lo), .dump_data_hi(dump_data_hi),
    .dump_done(dump_done),
    .bank_wrEn(bank_wrEn), .bank_addR1(bank_addR1), .bank_addR2(bank_addR2),
    .bank_addWr(bank_addWr), .bank_dadoWr(bank_dadoWr),
    .bank_dadoR1(bank_dadoR1), .bank_dadoR2(bank_dadoR2)
  );

  logic [7:0] regs [8];

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
      bank_dadoR1 <= 8'h00;
      bank_dadoR2 <= 8'h00;
    end else begin
      if (bank_wrEn) regs[bank_addWr] <= bank_dadoWr;
      bank_dadoR1 <= regs[bank_addR1];
      bank_dadoR2 <= regs[bank_addR2];
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic       wb;
    logic [2:0] wa;
    logic [7:0] wd;
    logic       rd;
    logic [2:0] a1;
    logic [2:0] a2;
    logic       e_wb;
    logic       e_rd;
    logic       e_rv;
    logic [7:0] e_d1;
    logic [7:0] e_d2;
  } vec_t;

  vec_t vecs [17];

  task automatic idle_inputs();
    wb_req = 1'b0; rd_req = 1'b0; dump_start = 1'b0;
  endtask

  // Monitors a dump from the cycle after dump_start; alt_rd issues operand reads on odd cycles.
  task automatic run_dump(input bit alt_rd);
    int k = 0;
    int dones = 0;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      dump_start = (j == 1);
      rd_req = alt_rd && (j % 2 == 1);
      rd_addr1 = 3'd7; rd_addr2 = 3'd0;
      #1;
      if (rd_valid && dump_valid) chk("valid_overlap", 1, 0);
      if (rd_valid) begin
        chk("ilv_rd_d1", rd_data1, 8'h17);
        chk("ilv_rd_d2", rd_data2, 8'h10);
      end
      if (dump_done) dones++;
      if (dump_valid) begin
        chk("dump_idx", dump_idx, 2 * k);
        chk("dump_lo", dump_data_lo, 8'h10 + 2 * k);
        chk("dump_hi", dump_data_hi, 8'h11 + 2 * k);
        chk("dump_done_last", dump_done, (k == 3) ? 1 : 0);
        k++;
      end
    end
    idle_inputs();
    chk("dump_pairs", k, 4);
    chk("dump_done_cnt", dones, 1);
    chk("dump_busy_end", dump_busy, 0);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[1]  = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 3'd0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00};
    vecs[2]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 8'h5A, 8'h00};
    vecs[3]  = '{1'b1, 3'd5, 8'hA5, 1'b1, 3'd5, 3'd3, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[4]  = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 3'd3, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00};
    vecs[5]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 8'hA5, 8'h5A};
    // Continuous write+read pressure: four writes, one forced read, repeat.
    for (int i = 6; i < 16; i++)
      vecs[i] = '{1'b1, 3'd1, 8'h11, 1'b1, 3'd1, 3'd5,
                  (i != 10 && i != 15), (i == 10 || i == 15), (i == 11), 8'h11, 8'hA5};
    vecs[16] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 8'h11, 8'hA5};

    wb_req = 1'b1; wb_addr = 3'd2; wb_data = 8'hEE; rd_req = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_wb_ack", wb_ack, 0);
    chk("rst_rd_ack", rd_ack, 0);
    chk("rst_wren", bank_wrEn, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_dump_valid", dump_valid, 0);
    chk("rst_dump_busy", dump_busy, 0);
    chk("rst_dump_done", dump_done, 0);
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      wb_req = vecs[i].wb; wb_addr = vecs[i].wa; wb_data = vecs[i].wd;
      rd_req = vecs[i].rd; rd_addr1 = vecs[i].a1; rd_addr2 = vecs[i].a2;
      #1;
      chk($sformatf("v%0d_wb_ack", i), wb_ack, vecs[i].e_wb);
      chk($sformatf("v%0d_wren", i), bank_wrEn, vecs[i].e_wb);
      chk($sformatf("v%0d_rd_ack", i), rd_ack, vecs[i].e_rd);
      chk($sformatf("v%0d_rd_valid", i), rd_valid, vecs[i].e_rv);
      if (vecs[i].e_rv) begin
        chk($sformatf("v%0d_d1", i), rd_data1, vecs[i].e_d1);
        chk($sformatf("v%0d_d2", i), rd_data2, vecs[i].e_d2);
      end
    end

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      wb_req = 1'b1; rd_req = 1'b0; wb_addr = 3'(i); wb_data = 8'h10 + 8'(i);
    end
    @(negedge clk);
    idle_inputs();

    @(negedge clk);
    dump_start = 1'b1;
    #1 chk("dump_busy_pre", dump_busy, 0);
    @(negedge clk);
    dump_start = 1'b0;
    #1 chk("dump_busy_on", dump_busy, 1);
    run_dump(1'b0);

    @(negedge clk);
    dump_start = 1'b1;
    run_dump(1'b1);

    begin
      bit seen = 1'b0;
      @(negedge clk);
      dump_start = 1'b1;
      for (int j = 0; j < 20 && !seen; j++) begin
        @(negedge clk);
        dump_start = 1'b0;
        #1 seen = dump_valid && (dump_idx == 3'd2);
      end
      chk("rst_mid_dump_reached", seen, 1);
    end
    rst = 1'b0; wb_req = 1'b1; wb_addr = 3'd3; wb_data = 8'hFF; rd_req = 1'b1;
    #1;
    chk("mid_rst_wb_ack", wb_ack, 0);
    chk("mid_rst_rd_ack", rd_ack, 0);
    chk("mid_rst_wren", bank_wrEn, 0);
    @(negedge clk);
    #1;
    chk("mid_rst_wren2", bank_wrEn, 0);
    chk("mid_rst_done", dump_done, 0);
    chk("mid_rst_busy", dump_busy, 0);
    rst = 1'b1;
    idle_inputs();
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      #1;
      chk("post_rst_done", dump_done, 0);
      chk("post_rst_dvalid", dump_valid, 0);
    end
    @(negedge clk);
    rd_req = 1'b1; rd_addr1 = 3'd3; rd_addr2 = 3'd5;
    #1 chk("post_rst_rd_ack", rd_ack, 1);
    @(negedge clk);
    rd_req = 1'b0;
    #1;
    chk("post_rst_rv", rd_valid, 1);
    chk("post_rst_d1", rd_data1, 8'h00);
    chk("post_rst_d2", rd_data2, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
